// File: rtl/key_event_decoder_pkg.sv
// Shared state encodings and default 50 MHz timing constants for the key gesture decoder.
package key_event_decoder_pkg;

    localparam int DEF_LONG_CNT   = 50_000_000;  // 1 s hold
    localparam int DEF_DBL_CNT    = 15_000_000;  // 300 ms double-click window
    localparam int DEF_REPEAT_CNT = 5_000_000;   // 100 ms auto-repeat
    localparam int DEF_CNT_W      = 26;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_PRESS1 = 5'b00010,
        ST_WAIT2  = 5'b00100,
        ST_PRESS2 = 5'b01000,
        ST_LONG   = 5'b10000
    } state_t;

endpackage

// File: rtl/key_event_decoder.sv
// Classifies debounced key events into short/double/long press pulses plus auto-repeat.
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int LONG_CNT   = DEF_LONG_CNT,
    parameter int DBL_CNT    = DEF_DBL_CNT,
    parameter int REPEAT_CNT = DEF_REPEAT_CNT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic key_held
);

    generate
        if (LONG_CNT < 2 || DBL_CNT < 2 || REPEAT_CNT < 2) begin : g_bad_cnt
            $error("key_event_decoder: LONG_CNT, DBL_CNT and REPEAT_CNT must all be >= 2");
        end
        if ((64'(LONG_CNT) - 1 >= (64'd1 << CNT_W)) ||
            (64'(DBL_CNT) - 1 >= (64'd1 << CNT_W)) ||
            (64'(REPEAT_CNT) - 1 >= (64'd1 << CNT_W))) begin : g_bad_w
            $error("key_event_decoder: CNT_W too narrow for the terminal counts");
        end
    endgenerate

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             cnt_wrap;
    logic             short_nx, double_nx, long_nx, rep_nx;

    logic press_ev, rel_ev;
    logic long_tc, dbl_tc, rep_tc;

    assign press_ev = key_flag & ~key_state;
    assign rel_ev   = key_flag &  key_state;
    assign long_tc  = (cnt == CNT_W'(LONG_CNT - 1));
    assign dbl_tc   = (cnt == CNT_W'(DBL_CNT - 1));
    assign rep_tc   = (cnt == CNT_W'(REPEAT_CNT - 1));

    // Matching key events take priority over the timeouts; mismatched events
    // (e.g. a press while already pressed) are treated as if absent.
    always_comb begin
        state_nx  = state;
        short_nx  = 1'b0;
        double_nx = 1'b0;
        long_nx   = 1'b0;
        rep_nx    = 1'b0;
        cnt_wrap  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press_ev) state_nx = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (rel_ev) begin
                    state_nx = ST_WAIT2;
                end else if (long_tc) begin
                    state_nx = ST_LONG;
                    long_nx  = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (press_ev) begin
                    state_nx = ST_PRESS2;
                end else if (dbl_tc) begin
                    state_nx = ST_IDLE;
                    short_nx = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (rel_ev) begin
                    state_nx  = ST_IDLE;
                    double_nx = 1'b1;
                end else if (long_tc) begin
                    // first click already completed; the second press becomes a hold
                    state_nx = ST_LONG;
                    short_nx = 1'b1;
                    long_nx  = 1'b1;
                end
            end
            ST_LONG: begin
                if (rel_ev) begin
                    state_nx = ST_IDLE;
                end else if (rep_tc) begin
                    rep_nx   = 1'b1;
                    cnt_wrap = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            state        <= state_nx;
            short_press  <= short_nx;
            double_press <= double_nx;
            long_press   <= long_nx;
            repeat_pulse <= rep_nx;
            key_held     <= (state_nx == ST_PRESS1) || (state_nx == ST_PRESS2) ||
                            (state_nx == ST_LONG);
            if (state_nx != state || cnt_wrap || state == ST_IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule
